data_port_arbiter: RTL and testbench

Shares data port B of the main memory between the CPU data path and one DMA requester (sprite/OAM loader, boot loader). The CPU normally wins. A starvation counter forces a DMA slot after a bounded wait. The block also enforces the data-region boundary: addresses 0x400–0xFFF are data space, and 0x000–0x3FF belong to instruction memory on port A. It sits between the CPU memory stage / DMA engine and the memory's port-B pins. Memory timing: port B is clocked on the inverted `clk`, so `mem_rdata` is valid before the next rising edge of the cycle that drove the address.

---
 rtl/data_port_arbiter.sv | 97 +++++++++
 tb/tb_data_port_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_port_arbiter.sv
// Port-B arbiter: CPU data path vs. one DMA requester, with starvation-forced DMA slots
// and enforcement of the data-region lower boundary.
module data_port_arbiter #(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] DATA_BASE  = 12'h400,
  parameter int                STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd_en,
  input  logic              cpu_wr_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_fault,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              dma_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_DMA} owner_e;

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  logic     [2:0] starve_cnt;
  logic           cpu_act, cpu_low, dma_bad, force_slot;
  owner_e         owner;
  mem_req_t       mreq;

  assign cpu_act    = cpu_rd_en | cpu_wr_en;
  assign cpu_low    = cpu_addr < DATA_BASE;
  assign dma_bad    = dma_addr < DATA_BASE;
  assign force_slot = starve_cnt == STARVE_LIM;

  // Reset holds the owner idle, which zeroes every combinational output.
  always_comb begin
    owner = OWN_IDLE;
    if (!rst) begin
      if (dma_req && (!cpu_act || force_slot)) owner = OWN_DMA;
      else if (cpu_act)                        owner = OWN_CPU;
    end
  end

  always_comb begin
    mreq = '0;
    case (owner)
      OWN_CPU: mreq = '{en: 1'b1, we: cpu_wr_en & ~cpu_low, addr: cpu_addr, wdata: cpu_wdata};
      OWN_DMA: if (!dma_bad) mreq = '{en: 1'b1, we: dma_we, addr: dma_addr, wdata: dma_wdata};
      default: mreq = '0;
    endcase
  end

  assign mem_en    = mreq.en;
  assign mem_we    = mreq.we;
  assign mem_addr  = mreq.addr;
  assign mem_wdata = mreq.wdata;
  assign dma_gnt   = owner == OWN_DMA;
  assign cpu_stall = cpu_act & (owner == OWN_DMA);
  assign cpu_rdata = (owner == OWN_CPU) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      dma_rvalid <= 1'b0;
      dma_err    <= 1'b0;
      cpu_fault  <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      if (dma_gnt || !dma_req) starve_cnt <= '0;
      else if (!force_slot)    starve_cnt <= starve_cnt + 3'd1;
      dma_rvalid <= (owner == OWN_DMA) & ~dma_we & ~dma_bad;
      if ((owner == OWN_DMA) && !dma_we && !dma_bad) dma_rdata <= mem_rdata;
      dma_err    <= (owner == OWN_DMA) & dma_bad;
      cpu_fault  <= (owner == OWN_CPU) & cpu_wr_en & cpu_low;
    end
  end

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed bench for data_port_arbiter with a falling-edge port-B memory model.
module tb_data_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd_en, cpu_wr_en;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_fault;
  logic        dma_req, dma_we;
  logic [11:0] dma_addr;
  logic [31:0] dma_wdata, dma_rdata;
  logic        dma_gnt, dma_rvalid, dma_err;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [0:4095];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_port_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cpu_fault(cpu_fault),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_err(dma_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Port B runs on the inverted clock.
  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic to_neg(); @(negedge clk); #1; endtask
  task automatic to_pos(); @(posedge clk); #1; endtask

  task automatic idle();
    cpu_rd_en = 0; cpu_wr_en = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h400] = 32'hDEADBEEF;
    mem[12'h3FF] = 32'hCAFEF00D;

    // Reset with every request active
    rst = 1;
    cpu_rd_en = 1; cpu_wr_en = 1; cpu_addr = 12'h400; cpu_wdata = 32'h11112222;
    dma_req = 1; dma_we = 1; dma_addr = 12'h500; dma_wdata = 32'h33334444;
    to_neg();
    chk("rst_gnt",   dma_gnt,   0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_en",    mem_en,    0);
    chk("rst_we",    mem_we,    0);
    chk("rst_addr",  mem_addr,  0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", cpu_rdata, 0);
    to_pos(); to_pos();
    chk("rst_rvalid", dma_rvalid, 0);
    chk("rst_err",    dma_err,    0);
    chk("rst_fault",  cpu_fault,  0);
    chk("rst_drdata", dma_rdata,  0);
    rst = 0; idle();

    // CPU read, zero latency
    cpu_rd_en = 1; cpu_addr = 12'h400;
    to_neg();
    chk("cpu_rd_data",  cpu_rdata, 32'hDEADBEEF);
    chk("cpu_rd_stall", cpu_stall, 0);
    to_pos(); idle();

    // DMA write then read-back
    dma_req = 1; dma_we = 1; dma_addr = 12'h500; dma_wdata = 32'h12345678;
    to_neg();
    chk("dma_wr_gnt", dma_gnt, 1);
    chk("dma_wr_we",  mem_we,  1);
    to_pos();
    dma_we = 0;
    to_neg();
    chk("dma_rd_gnt", dma_gnt, 1);
    chk("dma_rd_we",  mem_we,  0);
    to_pos();
    chk("dma_rd_valid", dma_rvalid, 1);
    chk("dma_rd_data",  dma_rdata,  32'h12345678);
    dma_req = 0;
    to_pos();
    chk("dma_rd_pulse", dma_rvalid, 0);

    // Starvation: DMA held against continuous CPU reads
    cpu_rd_en = 1; cpu_addr = 12'h400;
    dma_req = 1; dma_we = 0; dma_addr = 12'h500;
    for (int c = 1; c <= 4; c++) begin
      to_neg();
      chk($sformatf("starve_gnt_c%0d", c),   dma_gnt,   0);
      chk($sformatf("starve_stall_c%0d", c), cpu_stall, 0);
      to_pos();
    end
    to_neg();
    chk("force_gnt",   dma_gnt,   1);
    chk("force_stall", cpu_stall, 1);
    chk("force_rdata", cpu_rdata, 0);
    chk("force_addr",  mem_addr,  12'h500);
    to_pos();
    chk("force_rvalid", dma_rvalid, 1);
    chk("force_drdata", dma_rdata,  32'h12345678);
    to_neg();
    chk("post_force_stall", cpu_stall, 0);
    chk("post_force_gnt",   dma_gnt,   0);
    chk("post_force_rdata", cpu_rdata, 32'hDEADBEEF);
    to_pos(); idle();

    // Boundary: DMA below data base rejected, at base serviced
    dma_req = 1; dma_we = 0; dma_addr = 12'h3FF;
    to_neg();
    chk("bad_dma_gnt", dma_gnt, 1);
    chk("bad_dma_en",  mem_en,  0);
    to_pos();
    chk("bad_dma_err",    dma_err,    1);
    chk("bad_dma_rvalid", dma_rvalid, 0);
    dma_addr = 12'h400;
    to_neg();
    chk("base_dma_en", mem_en, 1);
    to_pos();
    chk("base_dma_rvalid", dma_rvalid, 1);
    chk("base_dma_rdata",  dma_rdata,  32'hDEADBEEF);
    chk("base_dma_err",    dma_err,    0);
    idle();

    // CPU write below base suppressed, read there allowed
    cpu_wr_en = 1; cpu_addr = 12'h3FF; cpu_wdata = 32'h11111111;
    to_neg();
    chk("low_wr_we", mem_we, 0);
    chk("low_wr_en", mem_en, 1);
    to_pos();
    chk("low_wr_fault", cpu_fault, 1);
    cpu_wr_en = 0; cpu_rd_en = 1;
    to_neg();
    chk("low_rd_data", cpu_rdata, 32'hCAFEF00D);
    to_pos();
    chk("low_rd_fault", cpu_fault, 0);
    idle();

    // Simultaneous CPU write and DMA request with no starvation
    cpu_wr_en = 1; cpu_addr = 12'h600; cpu_wdata = 32'hA5A5A5A5;
    dma_req = 1; dma_we = 0; dma_addr = 12'h400;
    to_neg();
    chk("sim_gnt",   dma_gnt,   0);
    chk("sim_we",    mem_we,    1);
    chk("sim_stall", cpu_stall, 0);
    to_pos();
    cpu_wr_en = 0; cpu_rd_en = 1;
    to_neg();
    chk("sim_readback", cpu_rdata, 32'hA5A5A5A5);
    to_pos();
    cpu_rd_en = 0;
    to_neg();
    chk("pre_rst_gnt", dma_gnt, 1);
    rst = 1;  // lands before the edge that would raise dma_rvalid
    to_pos();
    chk("rst_drop_rvalid", dma_rvalid, 0);
    cpu_rd_en = 1;
    to_neg();
    chk("rst_hold_gnt",   dma_gnt,   0);
    chk("rst_hold_stall", cpu_stall, 0);
    to_pos();
    chk("rst_starve_cnt", 32'(dut.starve_cnt), 0);
    chk("rst_hold_rvalid", dma_rvalid, 0);
    rst = 0; idle();
    to_pos();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
